fb_pixel_stream: RTL and testbench
==================================

Name: fb_pixel_stream

Overview:
- Parametrised framebuffer-to-VGA pixel streamer.
- Fetches packed words from a synchronous-read frame RAM and unpacks several pixels per word.
- A small prefetch FIFO hides the RAM read latency.
- Delivers one pixel per visible cycle to the VGA output stage; outputs zero during blanking.
- Sits between the frame RAM written by the serial receiver and the VGA timing generator.

Parameters:
- RAM_WIDTH, 48: RAM word width in bits; must be an integer multiple of PIXEL_BITS.
- PIXEL_BITS, 24: bits per pixel; must be a multiple of 3 (R,G,B equal width, R in MSBs).
- H_ACTIVE, 480: visible pixels per line.
- V_ACTIVE, 360: visible lines per frame.
- RAM_LATENCY, 1: cycles from ram_rd_en to valid ram_data; legal 1..3.
- FIFO_DEPTH, 4: prefetch FIFO depth in words; power of two, ≥ RAM_LATENCY+1.
- Derived: PPW = RAM_WIDTH/PIXEL_BITS; RAM_DEPTH = H_ACTIVE*V_ACTIVE/PPW; ADDR_BITS = $clog2(RAM_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse from the VGA timing generator during vertical blanking
- visible  in  1  high when the current VGA cycle is an active pixel
- ram_addr  out  ADDR_BITS  frame RAM read address
- ram_rd_en  out  1  read strobe; one word requested per high cycle
- ram_data  in  RAM_WIDTH  read data, valid RAM_LATENCY cycles after ram_rd_en
- pixel_out  out  PIXEL_BITS  registered pixel to the DAC/VGA pins
- pixel_valid  out  1  registered copy of the previous cycle's visible
- underflow  out  1  sticky flag: a visible cycle found no pixel available

Behaviour:
- Reset state: ram_addr=0, ram_rd_en=0, pixel_out=0, pixel_valid=0, underflow=0, FIFO empty, in-flight pipe cleared, state IDLE.
- States:
  - IDLE: no reads. frame_start -> FILL.
  - FILL: issue reads. When the FIFO holds ≥1 word -> STREAM.
  - STREAM: issue reads and consume pixels. After the H_ACTIVE*V_ACTIVE-th pixel is consumed -> IDLE.
- Read issue: ram_rd_en=1 in FILL/STREAM when (FIFO occupancy + in-flight reads) < FIFO_DEPTH and words issued this frame < RAM_DEPTH.
  - ram_addr increments after each issued read.
  - Issue stops at RAM_DEPTH-1; the address never wraps inside a frame.
- Data capture: a RAM_LATENCY-deep valid shift register tracks in-flight reads. ram_data is pushed into the FIFO in the cycle its valid bit emerges.
- Unpacking: pixel index 0 of a word is bits [PIXEL_BITS-1:0], ascending. After the last pixel (index PPW-1) is consumed, the word is popped and the index returns to 0.
- Output latency: 1 cycle. If visible is high in cycle N, pixel_out carries that pixel in cycle N+1 and pixel_valid=1 in N+1.
- When visible is low: pixel_out=0 next cycle, no consumption.
- Underflow: visible high with the FIFO empty (including in IDLE/FILL) -> pixel_out=0 next cycle, no consumption, underflow set. underflow clears only on frame_start or rst.
- frame_start while in any state:
  - ram_addr reset to 0; FIFO flushed; in-flight valid bits cleared, so late returns are dropped.
  - Pixel index and pixel counter reset to 0; underflow cleared; state -> FILL.
- frame_start and visible high in the same cycle: frame_start wins; no consumption; pixel_out=0 next cycle; underflow not set.
- Visible cycles after frame completion (state IDLE): pixel_out=0 and underflow set.
- rst mid-frame: all state returns to reset values in the next cycle. In-flight RAM returns are ignored.
- Counters:
  - Pixel counter width is $clog2(H_ACTIVE*V_ACTIVE+1).
  - All comparisons are unsigned.
  - Address arithmetic is done at ADDR_BITS with no overflow, because it is bounded by RAM_DEPTH-1.

Optional Feature:
- Macro: FB_TEST_PATTERN_EN.
- Defined:
  - Extra input test_mode (1 bit).
  - A column counter counts visible cycles modulo H_ACTIVE and resets on frame_start.
  - When test_mode=1, pixel_out shows 8 vertical colour bars, each H_ACTIVE/8 columns wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black; each channel is all-ones or zero.
  - RAM fetch and consumption continue unchanged, and underflow is never set while test_mode=1.
- Undefined: no test_mode port, no column counter, RAM data only.

Test Plan:
- All tests use H_ACTIVE=8, V_ACTIVE=2, RAM_WIDTH=48, PIXEL_BITS=24, RAM_LATENCY=2, which gives RAM_DEPTH=8.
- Word k holds {pixel 2k+1, pixel 2k}, with pixel n = 24'h0000n0 + n.
- Reset, then frame_start, then 4 idle cycles, then visible high for 16 cycles -> pixel_out sequence = pixels 0..15, one cycle after each visible cycle, pixel_valid=1; ram_addr reaches 7, no 9th read; underflow=0.
- Visible toggled 1,0,1,0 -> pixel_out = p0, 0, p1, 0; pixel index advances only on high cycles.
- Visible asserted in the cycle right after frame_start -> pixel_out=0, underflow=1. After the first word lands: p0, p1 stream normally, and underflow stays 1 until the next frame_start.
- frame_start issued mid-frame after pixel 5, with 2 reads in flight -> the late returns are dropped. The next visible pixels are p0, p1; ram_addr restarts at 0.
- Complete 16 pixels, then 2 more visible cycles -> pixel_out=0 for both, underflow=1, ram_rd_en stays 0.
- With FB_TEST_PATTERN_EN defined and test_mode=1: one visible line of 8 cycles -> pixel_out = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; underflow=0.

Source files
------------

// File: rtl/fb_pixel_stream.sv
// fb_pixel_stream: framebuffer-to-VGA pixel streamer.
// Prefetches packed words from a synchronous-read frame RAM into a small FIFO.
// It unpacks them into one registered pixel per visible cycle.
// Optional colour-bar generator: define FB_TEST_PATTERN_EN to add i_test_mode.
module fb_pixel_stream #(
  parameter int unsigned RAM_WIDTH   = 48,
  parameter int unsigned PIXEL_BITS  = 24,
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned V_ACTIVE    = 360,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned PPW        = RAM_WIDTH / PIXEL_BITS,
  localparam int unsigned RAM_DEPTH  = H_ACTIVE * V_ACTIVE / PPW,
  localparam int unsigned ADDR_BITS  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_visible,
`ifdef FB_TEST_PATTERN_EN
  input  logic                  i_test_mode,
`endif
  output logic [ADDR_BITS-1:0]  o_ram_addr,
  output logic                  o_ram_rd_en,
  input  logic [RAM_WIDTH-1:0]  i_ram_data,
  output logic [PIXEL_BITS-1:0] o_pixel_out,
  output logic                  o_pixel_valid,
  output logic                  o_underflow
);

  localparam int unsigned TOTAL    = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CNT_BITS = $clog2(TOTAL + 1);
  localparam int unsigned ISS_BITS = $clog2(RAM_DEPTH + 1);
  localparam int unsigned PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_BITS = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_BITS = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned FLT_BITS = $clog2(RAM_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ISS_BITS-1:0]   r_issued;
  logic [RAM_LATENCY-1:0] r_pipe;
  logic [RAM_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   r_wr_ptr, r_rd_ptr;
  logic [OCC_BITS-1:0]   r_count;
  logic [IDX_BITS-1:0]   r_idx;
  logic [CNT_BITS-1:0]   r_pix_cnt;
  logic [PIXEL_BITS-1:0] r_pixel;
  logic                  r_valid;
  logic                  r_under;

  logic [FLT_BITS-1:0]   w_inflight;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_consume;
  logic                  w_last_pix;
  logic                  w_under_hit;
  logic [RAM_WIDTH-1:0]  w_head;
  logic [PIXEL_BITS-1:0] w_pix;
  logic [PIXEL_BITS-1:0] w_pixel_next;
  logic                  w_test;
  logic [PIXEL_BITS-1:0] w_bar_pix;

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      w_inflight = w_inflight + FLT_BITS'(r_pipe[i]);
    end
  end

  assign w_empty    = (r_count == '0);
  // Space is reserved for in-flight words, so a returning word never meets a full FIFO.
  assign w_issue    = (r_state != StIdle) &&
                      ((32'(r_count) + 32'(w_inflight)) < FIFO_DEPTH) &&
                      (32'(r_issued) < RAM_DEPTH);
  // A frame_start flushes the pipe, so a word emerging in that cycle is dropped.
  assign w_push     = r_pipe[RAM_LATENCY-1] && !i_frame_start;
  assign w_consume  = i_visible && !i_frame_start && (r_state == StStream) && !w_empty;
  assign w_pop      = w_consume && (r_idx == IDX_BITS'(PPW - 1));
  assign w_last_pix = (r_pix_cnt == CNT_BITS'(TOTAL - 1));
  assign w_head     = r_mem[r_rd_ptr];

  // Select the current pixel out of the head word, index 0 in the LSBs.
  always_comb begin
    w_pix = '0;
    for (int j = 0; j < PPW; j++) begin
      if (r_idx == IDX_BITS'(j)) w_pix = w_head[j*PIXEL_BITS +: PIXEL_BITS];
    end
  end

`ifdef FB_TEST_PATTERN_EN
  localparam int unsigned COL_BITS = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int unsigned CH_BITS  = PIXEL_BITS / 3;

  logic [COL_BITS-1:0] r_col;
  logic [2:0]          w_bar;

  assign w_test = i_test_mode;

  // Bar index from the column; channels R/G/B follow ~bar[1], ~bar[2], ~bar[0].
  always_comb begin
    w_bar = 3'd7;
    if ((32'(r_col) / BAR_W) < 32'd8) w_bar = 3'(32'(r_col) / BAR_W);
    w_bar_pix = {{CH_BITS{~w_bar[1]}}, {CH_BITS{~w_bar[2]}}, {CH_BITS{~w_bar[0]}}};
  end

  // Column counter: visible cycles modulo H_ACTIVE, realigned by frame_start.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_frame_start) begin
      r_col <= '0;
    end else if (i_visible) begin
      r_col <= (32'(r_col) == H_ACTIVE - 1) ? '0 : r_col + 1'b1;
    end
  end
`else
  assign w_test    = 1'b0;
  assign w_bar_pix = '0;
`endif

  assign w_under_hit = i_visible && !i_frame_start && !w_consume && !w_test;

  // Next pixel value; frame_start forces blank.
  always_comb begin
    w_pixel_next = '0;
    if (!i_frame_start) begin
      if (w_test && i_visible) begin
        w_pixel_next = w_bar_pix;
      end else if (w_consume) begin
        w_pixel_next = w_pix;
      end
    end
  end

  // FSM next state; FILL leaves on the first landed word so FILL always sees an empty FIFO.
  always_comb begin
    w_state_next = r_state;
    if (i_frame_start) begin
      w_state_next = StFill;
    end else begin
      unique case (r_state)
        StIdle:   w_state_next = StIdle;
        StFill:   if (w_push) w_state_next = StStream;
        StStream: if (w_consume && w_last_pix) w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem[r_wr_ptr] <= i_ram_data;
    end
  end

  // Fetch, FIFO bookkeeping, unpacking and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr    <= '0;
      r_issued  <= '0;
      r_pipe    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_pix_cnt <= '0;
      r_pixel   <= '0;
      r_valid   <= 1'b0;
      r_under   <= 1'b0;
    end else if (i_frame_start) begin
      r_addr    <= '0;
      r_issued  <= '0;
      r_pipe    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_pix_cnt <= '0;
      r_pixel   <= '0;
      r_valid   <= i_visible;
      r_under   <= 1'b0;
    end else begin
      r_pipe[0] <= w_issue;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      if (w_issue) begin
        r_issued <= r_issued + 1'b1;
        // Address holds at the last word rather than wrapping.
        if (32'(r_addr) != RAM_DEPTH - 1) r_addr <= r_addr + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_consume) begin
        r_idx     <= w_pop ? '0 : r_idx + 1'b1;
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      if (w_under_hit) r_under <= 1'b1;
      r_pixel <= w_pixel_next;
      r_valid <= i_visible;
    end
  end

  assign o_ram_addr    = r_addr;
  assign o_ram_rd_en   = w_issue;
  assign o_pixel_out   = r_pixel;
  assign o_pixel_valid = r_valid;
  assign o_underflow   = r_under;

endmodule

// File: tb/tb_fb_pixel_stream.sv
// Bench for fb_pixel_stream: bench-side RAM, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fb_pixel_stream;

  localparam int unsigned RW     = 48;
  localparam int unsigned PB     = 24;
  localparam int unsigned HA     = 8;
  localparam int unsigned VA     = 2;
  localparam int unsigned LAT    = 2;
  localparam int unsigned FD     = 4;
  localparam int unsigned PPW    = RW / PB;
  localparam int unsigned TOTAL  = HA * VA;
  localparam int unsigned RDEPTH = TOTAL / PPW;
  localparam int unsigned AB     = $clog2(RDEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fs  = 1'b0;
  logic          vis = 1'b0;
  logic [AB-1:0] addr;
  logic          rd_en;
  logic [RW-1:0] rdata;
  logic [PB-1:0] pix;
  logic          pvalid;
  logic          under;
`ifdef FB_TEST_PATTERN_EN
  logic          tmode = 1'b0;
`endif

  always #5 clk = ~clk;

  fb_pixel_stream #(
    .RAM_WIDTH  (RW),
    .PIXEL_BITS (PB),
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .RAM_LATENCY(LAT),
    .FIFO_DEPTH (FD)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_start(fs),
    .i_visible    (vis),
`ifdef FB_TEST_PATTERN_EN
    .i_test_mode  (tmode),
`endif
    .o_ram_addr   (addr),
    .o_ram_rd_en  (rd_en),
    .i_ram_data   (rdata),
    .o_pixel_out  (pix),
    .o_pixel_valid(pvalid),
    .o_underflow  (under)
  );

  // Frame content: pixel n = 0x0000n0 + n, word k packs pixels k*PPW.. ascending from LSB.
  function automatic logic [PB-1:0] pval(input int n);
    return PB'(n * 17);
  endfunction

  function automatic logic [RW-1:0] word(input int k);
    logic [RW-1:0] w;
    w = '0;
    for (int j = 0; j < PPW; j++) w[j*PB +: PB] = pval(k * PPW + j);
    return w;
  endfunction

  logic [PB-1:0] bars [8];
  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
  end

  // Bench frame RAM: data appears LAT cycles after the read strobe, junk otherwise.
  logic [LAT-1:0] ram_v = '0;
  int             ram_a [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      ram_v[i] <= ram_v[i-1];
      ram_a[i] <= ram_a[i-1];
    end
    ram_v[0] <= rd_en;
    ram_a[0] <= int'(addr);
  end
  assign rdata = ram_v[LAT-1] ? word(ram_a[LAT-1]) : {3{16'hDEAD}};

  int n_pass  = 0;
  int n_total = 0;
  int rd_cnt  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: words held, reads outstanding with landing times, frame progress.
  logic [RW-1:0] m_fifo [$];
  int            m_inft [$];
  int            m_infa [$];
  bit            m_active = 0;
  bit            m_under  = 0;
  bit            m_on     = 0;
  int            m_addr   = 0;
  int            m_issued = 0;
  int            m_idx    = 0;
  int            m_pix    = 0;
  int            m_col    = 0;
  int            cyc      = 0;
  logic [PB-1:0] e_pix    = '0;
  bit            e_valid  = 0;

  function automatic bit m_issue();
    return m_active && (m_fifo.size() + m_infl_size() < FD) && (m_issued < RDEPTH);
  endfunction

  function automatic int m_infl_size();
    return m_inft.size();
  endfunction

  always @(posedge clk) begin
    bit            iss;
    bit            cons;
    bit            tm;
    logic [RW-1:0] hw;
    cyc++;
    tm = 0;
`ifdef FB_TEST_PATTERN_EN
    tm = tmode;
`endif
    if (rst) begin
      m_fifo.delete(); m_inft.delete(); m_infa.delete();
      m_active = 0; m_under = 0; m_addr = 0; m_issued = 0;
      m_idx = 0; m_pix = 0; m_col = 0; e_pix = '0; e_valid = 0; m_on = 1;
    end else if (fs) begin
      m_fifo.delete(); m_inft.delete(); m_infa.delete();
      m_active = 1; m_under = 0; m_addr = 0; m_issued = 0;
      m_idx = 0; m_pix = 0; m_col = 0; e_pix = '0; e_valid = vis;
    end else begin
      iss     = m_issue();
      cons    = m_active && (m_fifo.size() > 0) && vis;
      e_valid = vis;
      e_pix   = '0;
      if (cons) begin
        hw    = m_fifo[0];
        e_pix = hw[m_idx*PB +: PB];
        m_idx++;
        if (m_idx == PPW) begin
          void'(m_fifo.pop_front());
          m_idx = 0;
        end
        m_pix++;
        if (m_pix == TOTAL) m_active = 0;
      end
      if (tm && vis) e_pix = bars[(m_col / (HA / 8)) % 8];
      if (vis && !cons && !tm) m_under = 1;
      if (vis) m_col = (m_col + 1) % HA;
      if (m_inft.size() > 0 && m_inft[0] == cyc) begin
        m_fifo.push_back(word(m_infa[0]));
        void'(m_inft.pop_front());
        void'(m_infa.pop_front());
      end
      if (iss) begin
        m_inft.push_back(cyc + LAT);
        m_infa.push_back(m_addr);
        m_issued++;
        if (m_addr < RDEPTH - 1) m_addr++;
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("pixel_out", 64'(pix), 64'(e_pix));
      check("pixel_valid", 64'(pvalid), 64'(e_valid));
      check("underflow", 64'(under), 64'(m_under));
      check("ram_rd_en", 64'(rd_en), 64'(m_issue()));
      check("ram_addr", 64'(addr), 64'(m_addr));
    end
    if (rd_en) rd_cnt++;
  end

  logic [PB-1:0] lp;
  logic          lu, lv, lrd;
  logic [AB-1:0] la;
  logic [PB-1:0] got [TOTAL];

  task automatic step(input bit f, input bit v, input bit r);
    fs = f; vis = v; rst = r;
    @(posedge clk);
    #1;
    fs = 0; vis = 0; rst = 0;
    lp = pix; lu = under; lv = pvalid; la = addr; lrd = rd_en;
  endtask

  initial begin
    int r;
    step(0, 0, 1);
    step(0, 0, 1);
    check("reset_pixel", 64'(lp), 64'h0);
    check("reset_valid", 64'(lv), 64'h0);
    check("reset_under", 64'(lu), 64'h0);
    check("reset_rd_en", 64'(lrd), 64'h0);
    check("reset_addr", 64'(la), 64'h0);

    // Full frame, then two visible cycles past the end.
    rd_cnt = 0;
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    for (int i = 0; i < TOTAL; i++) begin
      step(0, 1, 0);
      got[i] = lp;
      check("t1_valid", 64'(lv), 64'h1);
    end
    check("t1_p0", 64'(got[0]), 64'h000000);
    check("t1_p1", 64'(got[1]), 64'h000011);
    check("t1_p5", 64'(got[5]), 64'h000055);
    check("t1_p15", 64'(got[15]), 64'h0000FF);
    check("t1_under", 64'(lu), 64'h0);
    check("t1_addr", 64'(la), 64'h7);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0);
      check("t5_pixel", 64'(lp), 64'h0);
      check("t5_under", 64'(lu), 64'h1);
      check("t5_rd_en", 64'(lrd), 64'h0);
    end
    check("t1_reads", 64'(rd_cnt), 64'd8);

    // Visible toggling.
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    step(0, 1, 0); check("t2_a", 64'(lp), 64'h000000); check("t2_va", 64'(lv), 64'h1);
    step(0, 0, 0); check("t2_b", 64'(lp), 64'h000000); check("t2_vb", 64'(lv), 64'h0);
    step(0, 1, 0); check("t2_c", 64'(lp), 64'h000011);
    step(0, 0, 0); check("t2_d", 64'(lp), 64'h000000);
    check("t2_under", 64'(lu), 64'h0);

    // Visible right after frame_start.
    step(1, 0, 0);
    step(0, 1, 0);
    check("t3_pix", 64'(lp), 64'h0);
    check("t3_under", 64'(lu), 64'h1);
    repeat (4) step(0, 0, 0);
    step(0, 1, 0); check("t3_p0", 64'(lp), 64'h000000);
    step(0, 1, 0); check("t3_p1", 64'(lp), 64'h000011);
    check("t3_sticky", 64'(lu), 64'h1);

    // frame_start mid-frame after pixel 5.
    step(1, 0, 0);
    check("t4_under_clr", 64'(lu), 64'h0);
    repeat (4) step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    check("t4_p5", 64'(lp), 64'h000055);
    step(1, 1, 0);
    check("t4_fs_pix", 64'(lp), 64'h0);
    check("t4_fs_under", 64'(lu), 64'h0);
    check("t4_addr", 64'(la), 64'h0);
    repeat (4) step(0, 0, 0);
    step(0, 1, 0); check("t4_p0", 64'(lp), 64'h000000);
    step(0, 1, 0); check("t4_p1", 64'(lp), 64'h000011);
    step(0, 1, 0); check("t4_p2", 64'(lp), 64'h000022);

`ifdef FB_TEST_PATTERN_EN
    tmode = 1'b1;
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      check("tp_bar", 64'(lp), 64'(bars[i]));
    end
    check("tp_under", 64'(lu), 64'h0);
    tmode = 1'b0;
`endif

    // Randomised frames with occasional restarts and resets.
    for (int f = 0; f < 8; f++) begin
      step(1, 0, 0);
      for (int c = 0; c < 40; c++) begin
        r = $urandom_range(0, 99);
        step(r < 2, $urandom_range(0, 3) != 0, r == 99);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
